xpar_uart: RTL

- Memory-mapped UART peripheral attached to the processor top's external parallel interface: par_addr, par_re, par_we and par_out drive it, and its data_out feeds par_in.
- Converts processor byte writes into an 8N1 serial stream on txd, and deserialises rxd into a readable byte with status flags.
- Lets firmware run simple serial I/O without the debug char printer.

---
 rtl/xpar_uart_pkg.sv | 27 ++
 rtl/xuart_rx.sv | 106 ++++++++++
 rtl/xpar_uart.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/xpar_uart_pkg.sv
// Shared register map, status bit positions and FSM encoding for the parallel-bus UART.
package xpar_uart_pkg;

    // Register offsets on addr[1:0]
    localparam logic [1:0] UART_DATA = 2'd0;
    localparam logic [1:0] UART_STAT = 2'd1;
    localparam logic [1:0] UART_DIV  = 2'd2;

    // STATUS bit positions
    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_RX_OVF   = 2;
    localparam int ST_FRM_ERR  = 3;
    localparam int ST_TX_DROP  = 4;

    // Smallest divisor the bit counters can work with
    localparam int DIV_MIN = 4;

    // Common frame FSM encoding for TX and RX
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/xuart_rx.sv
// Receive path: 2-flop synchroniser, falling-edge start detect and 8N1 deframer.
// Emits a one-cycle done pulse with the frame-error flag on the stop-bit sample edge.
module xuart_rx
    import xpar_uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic [DIV_W-1:0] div,
    output logic [7:0]       rx_byte,
    output logic             rx_done,
    output logic             rx_frm_err
);

    localparam logic [DIV_W-1:0] ONE = 1;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detect
    logic [2:0]       sync_q;
    logic             rxd_s;
    logic             rxd_prev;

    uart_state_t      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;

    assign rxd_s    = sync_q[1];
    assign rxd_prev = sync_q[2];
    assign rx_byte  = sh_q;

    // Synchroniser chain; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[1:0], rxd};
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // Next-state: start bit checked at mid-bit, then one sample per divisor period
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_done    = 1'b0;
        rx_frm_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxd_s && rxd_prev) begin
                    state_d = S_START;
                    cnt_d   = (div >> 1) - ONE;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rxd_s) begin
                        // too short to be a start bit
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = div - ONE;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rxd_s, sh_q[7:1]};
                    cnt_d = div - ONE;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    rx_done    = 1'b1;
                    rx_frm_err = !rxd_s;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/xpar_uart.sv
// Memory-mapped UART on the processor parallel port: register file, read mux and TX FSM.
// The receive deframer lives in xuart_rx.
module xpar_uart
    import xpar_uart_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = 16'd868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              rxd,
    output logic              txd
);

    localparam logic [DIV_W-1:0] ONE     = 1;
    localparam logic [DIV_W-1:0] DIV_LOW = DIV_W'(DIV_MIN);

    logic             wr_data, wr_stat, wr_div, rd_data;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       hold_q;
    logic             hold_full;
    logic             tx_drop, rx_ovf, frm_err, rx_valid;
    logic [7:0]       rx_byte_q;
    logic [4:0]       status;

    uart_state_t      tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             txd_q, txd_d;
    logic             tx_load;

    logic [7:0]       rx_byte;
    logic             rx_done, rx_frm_err;

    // Bits above the divisor width carry no register content
    logic             unused_bits;
    assign unused_bits = ^data_in[DATA_W-1:DIV_W];

    assign wr_data = we && (addr == UART_DATA);
    assign wr_stat = we && (addr == UART_STAT);
    assign wr_div  = we && (addr == UART_DIV);
    assign rd_data = re && (addr == UART_DATA);
    assign txd     = txd_q;

    assign status = {tx_drop, frm_err, rx_ovf, rx_valid, !hold_full};

    xuart_rx #(.DIV_W(DIV_W)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .div        (div_q),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .rx_frm_err (rx_frm_err)
    );

    // Read mux, purely combinational and zero outside a read strobe
    always_comb begin
        data_out = '0;
        if (re) begin
            case (addr)
                UART_DATA: data_out[7:0]       = rx_byte_q;
                UART_STAT: data_out[4:0]       = status;
                UART_DIV:  data_out[DIV_W-1:0] = div_q;
                default:   data_out            = '0;
            endcase
        end
    end

    // Divisor register, clamped so half-bit timing stays meaningful
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        div_q <= DIV_RST;
        else if (wr_div) div_q <= (data_in[DIV_W-1:0] < DIV_LOW) ? DIV_LOW : data_in[DIV_W-1:0];
    end

    // TX holding register; a write while it is still full is lost and flagged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
            tx_drop   <= 1'b0;
        end else begin
            if (tx_load) hold_full <= 1'b0;
            if (wr_data && !hold_full) begin
                hold_q    <= data_in[7:0];
                hold_full <= 1'b1;
            end
            if (wr_stat && data_in[ST_TX_DROP]) tx_drop <= 1'b0;
            if (wr_data && hold_full)           tx_drop <= 1'b1;
        end
    end

    // RX byte and flags; a read on the delivery edge frees the slot for the new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte_q <= '0;
            rx_valid  <= 1'b0;
            rx_ovf    <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            if (wr_stat && data_in[ST_RX_OVF])  rx_ovf  <= 1'b0;
            if (wr_stat && data_in[ST_FRM_ERR]) frm_err <= 1'b0;
            if (rx_done) begin
                if (!rx_valid || rd_data) begin
                    rx_byte_q <= rx_byte;
                    rx_valid  <= 1'b1;
                end else begin
                    rx_ovf <= 1'b1;
                end
                if (rx_frm_err) frm_err <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // TX FSM registers; txd resets high without waiting for a clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
        end
    end

    // TX next-state: each slot lasts div cycles; a pending byte follows STOP with no gap
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (hold_full) begin
                    tx_load    = 1'b1;
                    tx_state_d = S_START;
                    tx_cnt_d   = div_q - ONE;
                    tx_sh_d    = hold_q;
                    txd_d      = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = div_q - ONE;
                    tx_bit_d   = '0;
                    txd_d      = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = div_q - ONE;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        txd_d    = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (hold_full) begin
                        tx_load    = 1'b1;
                        tx_state_d = S_START;
                        tx_cnt_d   = div_q - ONE;
                        tx_sh_d    = hold_q;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = S_IDLE;
                        txd_d      = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - ONE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

endmodule
